count_capture: RTL and testbench

Capture stage directly downstream of the 4-bit free-running counter. On a trigger event it snapshots the counter's `out` value into a small FIFO and presents the snapshots to a consumer over a valid/ready handshake. It converts the counter's continuously changing value into discrete, buffered timestamps, and flags any captures lost to a full buffer.

---
 rtl/count_capture_pkg.sv | 12 +
 rtl/count_capture_if.sv | 13 +
 rtl/count_capture_fifo.sv | 73 +++++++
 rtl/count_capture.sv | 67 ++++++
 tb/tb_count_capture.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/count_capture_pkg.sv
// rtl/count_capture_pkg.sv - shared defaults and pointer-width helper for count_capture
package count_capture_pkg;

  localparam int CNT_W_DEF = 4;
  localparam int DEPTH_DEF = 4;

  // One extra bit beyond the index lets full and empty be told apart.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/count_capture_if.sv
// rtl/count_capture_if.sv - snapshot stream handshake between count_capture and its consumer
interface count_capture_if #(
  parameter int CNT_W = count_capture_pkg::CNT_W_DEF
) ();

  logic [CNT_W-1:0] cap_data;
  logic             cap_valid;
  logic             cap_ready;

  modport master (output cap_data, output cap_valid, input cap_ready);
  modport slave  (input cap_data, input cap_valid, output cap_ready);

endinterface

// File: rtl/count_capture_fifo.sv
// rtl/count_capture_fifo.sv - capture_fifo: show-ahead FIFO with flush, level/full and drop flag
module capture_fifo
  import count_capture_pkg::*;
#(
  parameter int W     = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      push,
  input  logic [W-1:0]              din,
  input  logic                      pop,
  output logic [W-1:0]              dout,
  output logic                      valid,
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      drop
);

  localparam int PW = ptr_w(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic          empty;
  logic          pop_ok;
  logic          push_ok;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                   (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);
  assign level   = wr_ptr_q - rd_ptr_q;
  assign valid   = !empty;
  assign dout    = mem_q[rd_ptr_q[PW-2:0]];
  assign pop_ok  = pop && !empty;
  // A pop in the same cycle frees the slot the full-time push needs.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && !push_ok && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q[PW-2:0]] = din;
        wr_ptr_d                = wr_ptr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/count_capture.sv
// rtl/count_capture.sv - trigger-driven counter snapshot buffer with sticky overflow
// COUNT_CAPTURE_EDGE_EN: capture on trig rising edge instead of every trig-high cycle.
module count_capture
  import count_capture_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CNT_W-1:0]          cnt_in,
  input  logic                      trig,
  input  logic                      clr,
  count_capture_if.master           cap,
  output logic [ptr_w(DEPTH)-1:0]   level,
  output logic                      full,
  output logic                      ovf
);

  logic cap_ev;
  logic drop;
  logic ovf_q, ovf_d;

`ifdef COUNT_CAPTURE_EDGE_EN
  logic trig_q, trig_d;

  always_comb begin
    trig_d = trig;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_d;
  end

  assign cap_ev = trig && !trig_q;
`else
  assign cap_ev = trig;
`endif

  capture_fifo #(.W(CNT_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (clr),
    .push  (cap_ev),
    .din   (cnt_in),
    .pop   (cap.cap_ready),
    .dout  (cap.cap_data),
    .valid (cap.cap_valid),
    .level (level),
    .full  (full),
    .drop  (drop)
  );

  always_comb begin
    ovf_d = ovf_q | drop;
    if (clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;

endmodule

// File: tb/tb_count_capture.sv
// tb/tb_count_capture.sv - directed and scoreboarded checks for count_capture
module tb_count_capture;

  logic       clk;
  logic       rst;
  logic [3:0] cnt_in;
  logic       trig;
  logic       clr;
  logic [2:0] level;
  logic       full;
  logic       ovf;
  int         n_checks;
  int         n_errors;

  count_capture_if #(.CNT_W(4)) cap_if ();

  count_capture #(.CNT_W(4), .DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .cnt_in (cnt_in),
    .trig   (trig),
    .clr    (clr),
    .cap    (cap_if.master),
    .level  (level),
    .full   (full),
    .ovf    (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef COUNT_CAPTURE_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [3:0] v);
    trig   = 1'b1;
    cnt_in = v;
    tick();
    trig   = 1'b0;
    tick();
  endtask

  task automatic flush();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic drain(input string tag, input logic [3:0] v);
    check({tag, "_valid"}, cap_if.cap_valid, 1);
    check({tag, "_data"}, cap_if.cap_data, v);
    cap_if.cap_ready = 1'b1;
    tick();
    cap_if.cap_ready = 1'b0;
  endtask

  initial begin
    int         q[$];
    bit         ovf_m, pt, pv, pr, r, t, pop, ev;
    logic [3:0] pd, v;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    cnt_in = 4'd0;
    trig = 1'b0;
    clr = 1'b0;
    cap_if.cap_ready = 1'b0;
    #1;
    check("rst_valid", cap_if.cap_valid, 0);
    check("rst_data", cap_if.cap_data, 0);
    check("rst_level", level, 0);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    tick();
    rst = 1'b0;

    // Asynchronous reset with entries stored, then first capture afterwards.
    push1(4'd1);
    push1(4'd2);
    push1(4'd3);
    check("pre_rst_level", level, 3);
    #3;
    rst = 1'b1;
    #1;
    check("arst_valid", cap_if.cap_valid, 0);
    check("arst_data", cap_if.cap_data, 0);
    check("arst_level", level, 0);
    tick();
    rst = 1'b0;
    trig = 1'b1;
    cnt_in = 4'd9;
    tick();
    trig = 1'b0;
    check("post_rst_valid", cap_if.cap_valid, 1);
    check("post_rst_data", cap_if.cap_data, 9);
    tick();
    flush();

    // Ordering across the counter wrap.
    push1(4'd14);
    push1(4'd15);
    push1(4'd0);
    push1(4'd1);
    check("ord_level", level, 4);
    check("ord_full", full, 1);
    drain("ord0", 4'd14);
    drain("ord1", 4'd15);
    drain("ord2", 4'd0);
    drain("ord3", 4'd1);
    check("ord_empty_valid", cap_if.cap_valid, 0);
    check("ord_empty_level", level, 0);

    // Overflow while full, then push plus pop while full.
    push1(4'd3);
    push1(4'd5);
    push1(4'd7);
    push1(4'd9);
    check("ovf_pre", ovf, 0);
    push1(4'd11);
    check("ovf_set", ovf, 1);
    check("ovf_level", level, 4);
    check("ovf_head", cap_if.cap_data, 3);
    trig = 1'b1;
    cnt_in = 4'd12;
    cap_if.cap_ready = 1'b1;
    tick();
    trig = 1'b0;
    cap_if.cap_ready = 1'b0;
    check("fullpop_level", level, 4);
    check("fullpop_ovf", ovf, 1);
    tick();
    drain("ovf0", 4'd5);
    drain("ovf1", 4'd7);
    drain("ovf2", 4'd9);
    drain("ovf3", 4'd12);
    check("ovf_sticky", ovf, 1);

    // Flush beats simultaneous push and pop.
    push1(4'd2);
    push1(4'd4);
    clr = 1'b1;
    trig = 1'b1;
    cnt_in = 4'd6;
    cap_if.cap_ready = 1'b1;
    tick();
    clr = 1'b0;
    trig = 1'b0;
    cap_if.cap_ready = 1'b0;
    check("clr_level", level, 0);
    check("clr_valid", cap_if.cap_valid, 0);
    check("clr_ovf", ovf, 0);
    tick();

    // trig held five cycles with the counter running.
    trig = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cnt_in = 4'(6 + i);
      tick();
    end
    trig = 1'b0;
    tick();
`ifdef COUNT_CAPTURE_EDGE_EN
    check("hold_level", level, 1);
    check("hold_ovf", ovf, 0);
    drain("hold0", 4'd6);
`else
    check("hold_level", level, 4);
    check("hold_ovf", ovf, 1);
    drain("hold0", 4'd6);
    drain("hold1", 4'd7);
    drain("hold2", 4'd8);
    drain("hold3", 4'd9);
`endif
    check("hold_empty", cap_if.cap_valid, 0);
    flush();
    tick();

    // Random backpressure against random triggers, scoreboarded.
    ovf_m = 1'b0;
    pt = 1'b0;
    pv = 1'b0;
    pr = 1'b0;
    pd = 4'd0;
    for (int c = 0; c < 300; c++) begin
      r = 1'($urandom_range(0, 1));
      t = ($urandom_range(0, 2) == 0);
      v = 4'($urandom_range(0, 15));
      cap_if.cap_ready = r;
      trig = t;
      cnt_in = v;
      check("rnd_valid", cap_if.cap_valid, (q.size() != 0) ? 1 : 0);
      check("rnd_level", level, q.size());
      check("rnd_full", full, (q.size() == 4) ? 1 : 0);
      check("rnd_ovf", ovf, ovf_m);
      if (q.size() != 0) check("rnd_data", cap_if.cap_data, q[0]);
      if (pv && !pr) check("rnd_stable", cap_if.cap_data, pd);
      pop = r && (q.size() != 0);
      ev = EDGE ? (t && !pt) : t;
      if (pop) void'(q.pop_front());
      if (ev) begin
        if (q.size() < 4) q.push_back(int'(v));
        else ovf_m = 1'b1;
      end
      pv = cap_if.cap_valid;
      pr = r;
      pd = cap_if.cap_data;
      pt = t;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
